vga_pattern_ctrl: RTL and testbench
===================================

# vga_pattern_ctrl

Frame-synchronous pattern scheduler feeding the VGA timing driver's `rgb_data` input. It turns the driver's active-area pixel address into a 24-bit colour for one of five built-in test patterns. It accepts manual pattern-change requests through a req/ack handshake and can optionally auto-cycle through patterns every N frames. All pattern changes are applied only at a frame boundary, so a displayed frame never mixes two patterns.

## Interface
- `INIT_PAT`, 3'd1: pattern selected after reset.
- `AUTO_FRAMES`, 120: frames per pattern in auto mode (1..4095).
- `GRID_LOG2`, 6: grid pitch is 2^GRID_LOG2 pixels.
- `CHK_LOG2`, 5: checker square size is 2^CHK_LOG2 pixels.
- `vga_clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `v_sync` in 1: frame sync from the timing driver, synchronous to `vga_clk`.
- `addr_h` in 12: active column, 1..640; 0 means outside the active area.
- `addr_v` in 12: active row, 1..480; 0 means outside the active area.
- `solid_rgb` in 24: colour used by pattern 0.
- `sel_req` in 1: one-cycle request to change pattern.
- `sel_pat` in 3: requested pattern, sampled when `sel_req`=1.
- `auto_en` in 1: enables auto-cycling (only when the macro is defined).
- `rgb_data` out 24: pixel colour sent to the driver.
- `sel_ack` out 1: one-cycle pulse when a request is applied.
- `sel_err` out 1: one-cycle pulse when a request is rejected.
- `busy` out 1: a request is pending.
- `pat_cur` out 3: pattern currently displayed.

## Operation
- **Patterns** (x = addr_h−1, y = addr_v−1):
  - 0 solid: `solid_rgb`.
  - 1 colour bars: bar = x/80, 8 bars. Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2 grid: FFFFFF when x[GRID_LOG2−1:0]==0 or y[GRID_LOG2−1:0]==0; otherwise 000000.
  - 3 gradient: grey level g = x[9:2]; colour is {g,g,g}.
  - 4 checker: FFFFFF when x[CHK_LOG2] XOR y[CHK_LOG2] is 1; otherwise 000000.
- `rgb_data` = 24'h0 whenever `addr_h`==0 or `addr_v`==0.
- **Frame boundary**: `fs` = `v_sync` & ~`v_sync_d`, where `v_sync_d` is a one-cycle registered copy of `v_sync`.
- **FSM states**:
  - HOLD: `sel_req` with `sel_pat`≤4 latches `pend_pat` and moves to PEND. `sel_req` with `sel_pat`≥5 pulses `sel_err` next cycle and stays in HOLD.
  - PEND: `busy`=1. A new valid `sel_req` overwrites `pend_pat` (last request wins). On `fs`, move to APPLY.
  - APPLY: lasts one cycle. `pat_cur`←`pend_pat`, `sel_ack`=1, frame counter cleared, return to HOLD.
- **Auto mode** (macro defined, `auto_en`=1, state HOLD):
  - The 12-bit frame counter increments on each `fs`.
  - When the count reaches AUTO_FRAMES−1 and `fs` occurs, `pat_cur` advances 0→1→2→3→4→0, the counter clears, and no `sel_ack` is produced.
- **Simultaneous events**:
  - A manual request always beats auto-advance.
  - A `sel_req` in the same cycle as `fs` while in HOLD is latched and applied at the next `fs`.
  - An invalid request arriving in PEND pulses `sel_err` and leaves `pend_pat` unchanged.
- `auto_en` deasserted: the counter holds its value.
- Reset mid-operation discards any pending request.

## Timing
- **Reset values**: `rgb_data`=0 (address is 0 in reset), `sel_ack`=0, `sel_err`=0, `busy`=0, `pat_cur`=INIT_PAT. Internally: FSM in HOLD, counter=0, `v_sync_d`=0.
- `rgb_data` is combinational from `addr_h`, `addr_v`, `pat_cur` and `solid_rgb`: zero cycles of latency.
- **Request path**: `sel_req` at cycle t gives `busy`=1 at t+1. A rising edge of `v_sync` at cycle f gives `fs` at f, APPLY at f+1, and `pat_cur`/`sel_ack` valid at f+2.
- `sel_err` is a single pulse at t+1.
- The switch falls inside vertical blanking, so there is no tearing.

## Configuration
- `VGA_PAT_AUTO_EN` defined: frame counter and auto-advance logic are present, and `auto_en` is honoured.
- Not defined: the counter is removed, `auto_en` is ignored, and patterns change only on request.

## Test plan
- Reset, then drive addr (1,1), (81,1) and (640,480) with pattern 1 → FFFFFF, FFFF00, 000000; addr (0,5) → 000000.
- `sel_req` with `sel_pat`=2 mid-frame → `busy`=1 next cycle. At the next `v_sync` rise, `pat_cur`=2 and `sel_ack` pulses once two cycles later. Grid check: (65,10) → FFFFFF, (66,10) → 000000.
- `sel_pat`=6 → `sel_err` pulses and `pat_cur` is unchanged. Then requests 3 and 4 in the same frame → `pat_cur`=4 with exactly one `sel_ack`.
- Macro on, AUTO_FRAMES=2, `auto_en`=1 → `pat_cur` steps 1→2→3→4→0→1 every 2 frames. A manual request to 0 during a count → applied, and the counter restarts.
- Assert `rst_n` low while in PEND → `busy`=0 and `pat_cur`=INIT_PAT. After release, no `sel_ack` is produced at the next frame.
- Gradient: (5,1) → 010101, (640,1) → 9F9F9F. Checker: (33,1) → FFFFFF, (33,33) → 000000.

Source files
------------

// File: rtl/vga_pattern_ctrl.sv
// Frame-synchronous test-pattern scheduler producing rgb_data for the VGA timing driver.
// Optional auto-cycling through patterns is compiled in with `define VGA_PAT_AUTO_EN.
module vga_pattern_ctrl #(
    parameter logic [2:0]  INIT_PAT    = 3'd1,
    parameter logic [11:0] AUTO_FRAMES = 12'd120,
    parameter int          GRID_LOG2   = 6,
    parameter int          CHK_LOG2    = 5
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        v_sync,
    input  logic [11:0] addr_h,
    input  logic [11:0] addr_v,
    input  logic [23:0] solid_rgb,
    input  logic        sel_req,
    input  logic [2:0]  sel_pat,
    input  logic        auto_en,
    output logic [23:0] rgb_data,
    output logic        sel_ack,
    output logic        sel_err,
    output logic        busy,
    output logic [2:0]  pat_cur
);

    // state | meaning
    // HOLD  | displaying pat_cur, no request outstanding
    // PEND  | request latched in pend_pat, waiting for frame start
    // APPLY | one cycle: commit pend_pat to pat_cur and pulse sel_ack
    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pend_pat_q, pend_pat_d;
    logic [2:0]  pat_cur_q, pat_cur_d;
    logic        sel_ack_q, sel_ack_d;
    logic        sel_err_q, sel_err_d;
    logic        v_sync_d_q, v_sync_d_d;
    logic        fs;
    logic        req_ok;
    logic        req_bad;

    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] bar;
    logic [23:0] rgb;

`ifdef VGA_PAT_AUTO_EN
    logic [11:0] frm_cnt_q, frm_cnt_d;
    logic [11:0] unused_y;
    assign unused_y = y;
`else
    logic [24:0] unused_cfg;
    assign unused_cfg = {auto_en, AUTO_FRAMES, y};
`endif

    assign fs      = v_sync & ~v_sync_d_q;
    assign req_ok  = sel_req & (sel_pat <= 3'd4);
    assign req_bad = sel_req & (sel_pat > 3'd4);

    always_comb begin
        state_d    = state_q;
        pend_pat_d = pend_pat_q;
        pat_cur_d  = pat_cur_q;
        sel_ack_d  = 1'b0;
        sel_err_d  = req_bad;
        v_sync_d_d = v_sync;
`ifdef VGA_PAT_AUTO_EN
        frm_cnt_d  = frm_cnt_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (req_ok) begin
                    pend_pat_d = sel_pat;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (req_ok) begin
                    pend_pat_d = sel_pat;
                end
                if (fs) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                pat_cur_d = pend_pat_q;
                sel_ack_d = 1'b1;
`ifdef VGA_PAT_AUTO_EN
                frm_cnt_d = '0;
`endif
                // a request landing on the apply cycle starts a fresh pending cycle
                if (req_ok) begin
                    pend_pat_d = sel_pat;
                    state_d    = ST_PEND;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
`ifdef VGA_PAT_AUTO_EN
        // manual request in HOLD pre-empts the auto step for this frame
        if (state_q == ST_HOLD && !req_ok && auto_en && fs) begin
            if (frm_cnt_q == AUTO_FRAMES - 12'd1) begin
                frm_cnt_d = '0;
                pat_cur_d = (pat_cur_q >= 3'd4) ? 3'd0 : pat_cur_q + 3'd1;
            end else begin
                frm_cnt_d = frm_cnt_q + 12'd1;
            end
        end
`endif
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            pend_pat_q <= INIT_PAT;
            pat_cur_q  <= INIT_PAT;
            sel_ack_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            v_sync_d_q <= 1'b0;
`ifdef VGA_PAT_AUTO_EN
            frm_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pend_pat_q <= pend_pat_d;
            pat_cur_q  <= pat_cur_d;
            sel_ack_q  <= sel_ack_d;
            sel_err_q  <= sel_err_d;
            v_sync_d_q <= v_sync_d_d;
`ifdef VGA_PAT_AUTO_EN
            frm_cnt_q  <= frm_cnt_d;
`endif
        end
    end

    assign x = addr_h - 12'd1;
    assign y = addr_v - 12'd1;

    always_comb begin
        rgb = 24'h000000;
        bar = x / 12'd80;
        if (addr_h != 12'd0 && addr_v != 12'd0) begin
            case (pat_cur_q)
                3'd0: rgb = solid_rgb;
                3'd1: begin
                    case (bar)
                        12'd0:   rgb = 24'hFFFFFF;
                        12'd1:   rgb = 24'hFFFF00;
                        12'd2:   rgb = 24'h00FFFF;
                        12'd3:   rgb = 24'h00FF00;
                        12'd4:   rgb = 24'hFF00FF;
                        12'd5:   rgb = 24'hFF0000;
                        12'd6:   rgb = 24'h0000FF;
                        default: rgb = 24'h000000;
                    endcase
                end
                3'd2: begin
                    if (x[GRID_LOG2-1:0] == '0 || y[GRID_LOG2-1:0] == '0) begin
                        rgb = 24'hFFFFFF;
                    end
                end
                3'd3: rgb = {x[9:2], x[9:2], x[9:2]};
                3'd4: begin
                    if (x[CHK_LOG2] ^ y[CHK_LOG2]) begin
                        rgb = 24'hFFFFFF;
                    end
                end
                default: rgb = 24'h000000;
            endcase
        end
    end

    assign rgb_data = rgb;
    assign sel_ack  = sel_ack_q;
    assign sel_err  = sel_err_q;
    assign busy     = (state_q == ST_PEND);
    assign pat_cur  = pat_cur_q;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Self-checking bench for vga_pattern_ctrl: random pixels and request sequences
// compared against an arithmetic reference of the pattern and scheduling rules.
module tb_vga_pattern_ctrl;

    localparam logic [2:0] INIT_PAT  = 3'd1;
    localparam int         GRID_LOG2 = 6;
    localparam int         CHK_LOG2  = 5;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        v_sync  = 1'b0;
    logic [11:0] addr_h  = '0;
    logic [11:0] addr_v  = '0;
    logic [23:0] solid_rgb = 24'h123456;
    logic        sel_req = 1'b0;
    logic [2:0]  sel_pat = '0;
    logic        auto_en = 1'b0;
    logic [23:0] rgb_data;
    logic        sel_ack;
    logic        sel_err;
    logic        busy;
    logic [2:0]  pat_cur;

    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt     = 0;
    int err_cnt     = 0;
    int exp_pat     = 1;
    logic [23:0] bar_col [8];

    vga_pattern_ctrl #(
        .INIT_PAT   (INIT_PAT),
        .AUTO_FRAMES(12'd2),
        .GRID_LOG2  (GRID_LOG2),
        .CHK_LOG2   (CHK_LOG2)
    ) dut (
        .vga_clk  (vga_clk),
        .rst_n    (rst_n),
        .v_sync   (v_sync),
        .addr_h   (addr_h),
        .addr_v   (addr_v),
        .solid_rgb(solid_rgb),
        .sel_req  (sel_req),
        .sel_pat  (sel_pat),
        .auto_en  (auto_en),
        .rgb_data (rgb_data),
        .sel_ack  (sel_ack),
        .sel_err  (sel_err),
        .busy     (busy),
        .pat_cur  (pat_cur)
    );

    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) begin
        if (sel_ack === 1'b1) ack_cnt++;
        if (sel_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int pat, input int h, input int v, input logic [23:0] solid);
        int x, y, g;
        if (h == 0 || v == 0) return 24'h0;
        x = h - 1;
        y = v - 1;
        case (pat)
            0: return solid;
            1: return (x / 80 < 8) ? bar_col[x / 80] : 24'h0;
            2: return ((x % (1 << GRID_LOG2)) == 0 || (y % (1 << GRID_LOG2)) == 0) ? 24'hFFFFFF : 24'h0;
            3: begin
                g = (x / 4) % 256;
                return g * 24'h010101;
            end
            4: return (((x / (1 << CHK_LOG2)) + (y / (1 << CHK_LOG2))) % 2 == 1) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] p);
        sel_pat = p;
        sel_req = 1'b1;
        cyc();
        sel_req = 1'b0;
        cyc();
    endtask

    task automatic do_frame();
        v_sync = 1'b1;
        repeat (3) cyc();
        v_sync = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pix(input string tag, input int h, input int v);
        addr_h = 12'(h);
        addr_v = 12'(v);
        #1;
        chk(tag, {8'h0, rgb_data}, {8'h0, ref_rgb(exp_pat, h, v, solid_rgb)});
    endtask

    task automatic set_pat(input int p);
        pulse_req(3'(p));
        do_frame();
        exp_pat = p;
        chk("set_pat", {29'h0, pat_cur}, exp_pat);
    endtask

    initial begin
        int acks0, errs0, last, nbad, nreq, p;
        bit any;
        bar_col = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

        #23;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_ack", {31'h0, sel_ack}, 0);
        chk("rst_err", {31'h0, sel_err}, 0);
        chk("rst_pat", {29'h0, pat_cur}, INIT_PAT);
        chk("rst_rgb", {8'h0, rgb_data}, 0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        cyc();

        exp_pat = 1;
        pix("bar_1_1", 1, 1);
        chk("bar_1_1_const", {8'h0, rgb_data}, 32'hFFFFFF);
        pix("bar_81_1", 81, 1);
        chk("bar_81_1_const", {8'h0, rgb_data}, 32'hFFFF00);
        pix("bar_640_480", 640, 480);
        pix("blank_0_5", 0, 5);
        chk("blank_0_5_const", {8'h0, rgb_data}, 0);

        // request 2 mid-frame, check exact latency
        cyc();
        acks0 = ack_cnt;
        sel_pat = 3'd2;
        sel_req = 1'b1;
        cyc();
        sel_req = 1'b0;
        chk("req_busy", {31'h0, busy}, 1);
        repeat (3) cyc();
        v_sync = 1'b1;
        cyc();
        chk("apply_pat_old", {29'h0, pat_cur}, 1);
        chk("apply_ack_early", {31'h0, sel_ack}, 0);
        cyc();
        chk("apply_pat_new", {29'h0, pat_cur}, 2);
        chk("apply_ack", {31'h0, sel_ack}, 1);
        cyc();
        chk("apply_ack_end", {31'h0, sel_ack}, 0);
        chk("apply_busy_end", {31'h0, busy}, 0);
        v_sync = 1'b0;
        repeat (3) cyc();
        chk("apply_ack_cnt", ack_cnt - acks0, 1);
        exp_pat = 2;
        pix("grid_65_10", 65, 10);
        pix("grid_66_10", 66, 10);
        chk("grid_66_10_const", {8'h0, rgb_data}, 0);

        // invalid request in HOLD
        sel_pat = 3'd6;
        sel_req = 1'b1;
        cyc();
        sel_req = 1'b0;
        chk("err_pulse", {31'h0, sel_err}, 1);
        chk("err_busy", {31'h0, busy}, 0);
        cyc();
        chk("err_pulse_end", {31'h0, sel_err}, 0);
        do_frame();
        chk("err_pat", {29'h0, pat_cur}, 2);

        // last request wins, single ack
        acks0 = ack_cnt;
        pulse_req(3'd3);
        pulse_req(3'd4);
        do_frame();
        chk("lastwin_pat", {29'h0, pat_cur}, 4);
        chk("lastwin_ack", ack_cnt - acks0, 1);

        // invalid request while pending leaves pend_pat alone
        errs0 = err_cnt;
        pulse_req(3'd3);
        pulse_req(3'd7);
        chk("pend_err_busy", {31'h0, busy}, 1);
        do_frame();
        chk("pend_err_pat", {29'h0, pat_cur}, 3);
        chk("pend_err_cnt", err_cnt - errs0, 1);
        exp_pat = 3;
        pix("grad_5_1", 5, 1);
        pix("grad_640_1", 640, 1);
        chk("grad_640_1_const", {8'h0, rgb_data}, 32'h9F9F9F);
        set_pat(4);
        pix("chk_33_1", 33, 1);
        pix("chk_33_33", 33, 33);

        // random pixels for every pattern
        for (int pt = 0; pt < 5; pt++) begin
            solid_rgb = 24'($urandom);
            set_pat(pt);
            for (int i = 0; i < 30; i++) begin
                pix("rand_pix", (i % 10 == 0) ? 0 : int'($urandom_range(1, 640)),
                    (i % 13 == 0) ? 0 : int'($urandom_range(1, 480)));
            end
        end

        // random request sequences, one frame each
        for (int k = 0; k < 20; k++) begin
            acks0 = ack_cnt;
            errs0 = err_cnt;
            nreq = $urandom_range(0, 3);
            any  = 0;
            last = exp_pat;
            nbad = 0;
            for (int r = 0; r < nreq; r++) begin
                p = $urandom_range(0, 7);
                pulse_req(3'(p));
                if (p <= 4) begin
                    any  = 1;
                    last = p;
                end else begin
                    nbad++;
                end
            end
            do_frame();
            exp_pat = last;
            chk("rnd_pat", {29'h0, pat_cur}, exp_pat);
            chk("rnd_ack", ack_cnt - acks0, any ? 1 : 0);
            chk("rnd_err", err_cnt - errs0, nbad);
            pix("rnd_pix", $urandom_range(1, 640), $urandom_range(1, 480));
        end

        // reset while pending
        if (exp_pat == 3) set_pat(2);
        pulse_req(3'd3);
        chk("rstpend_busy_pre", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("rstpend_busy", {31'h0, busy}, 0);
        chk("rstpend_pat", {29'h0, pat_cur}, INIT_PAT);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        acks0 = ack_cnt;
        do_frame();
        chk("rstpend_noack", ack_cnt - acks0, 0);
        chk("rstpend_pat_after", {29'h0, pat_cur}, INIT_PAT);
        exp_pat = 1;

`ifdef VGA_PAT_AUTO_EN
        acks0 = ack_cnt;
        auto_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            do_frame();
            if (k % 2 == 0) exp_pat = (exp_pat + 1) % 5;
            chk("auto_step", {29'h0, pat_cur}, exp_pat);
        end
        chk("auto_noack", ack_cnt - acks0, 0);
        do_frame();
        chk("auto_mid", {29'h0, pat_cur}, 1);
        pulse_req(3'd0);
        do_frame();
        chk("auto_manual", {29'h0, pat_cur}, 0);
        chk("auto_manual_ack", ack_cnt - acks0, 1);
        do_frame();
        chk("auto_restart", {29'h0, pat_cur}, 0);
        do_frame();
        chk("auto_after_restart", {29'h0, pat_cur}, 1);
        auto_en = 1'b0;
        do_frame();
        do_frame();
        chk("auto_off_hold", {29'h0, pat_cur}, 1);
`else
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_frame();
            chk("noauto_hold", {29'h0, pat_cur}, exp_pat);
        end
        auto_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
